// File: rtl/counter_pkg.sv
// counter_pkg: direction/mode encodings and the shared next-count rule for the up/down counter.
package counter_pkg;
  localparam int MAXW = 32;
  typedef logic [MAXW:0] wide_t;
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT = 1'b1;
  // Widened arithmetic keeps MODULUS = 2**WIDTH representable without overflow.
  function automatic wide_t next_count(input wide_t cnt, input logic dir, input logic sat,
                                       input wide_t modulus);
    return (dir == DIR_UP) ? ((cnt == modulus - 1'b1) ? (sat ? cnt : '0) : cnt + 1'b1)
                           : ((cnt == '0) ? (sat ? cnt : modulus - 1'b1) : cnt - 1'b1);
  endfunction
endpackage

// File: rtl/counter_prescaler.sv
// counter_prescaler: emits a tick every PRESCALE enabled cycles; clr restarts the phase.
module counter_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] phase_q, phase_d;
  always_comb begin
    tick = en & (phase_q == PW'(PRESCALE - 1));
    phase_d = clr ? '0 : !en ? phase_q : tick ? '0 : phase_q + 1'b1;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) phase_q <= '0;
    else phase_q <= phase_d;
  end
endmodule

// File: rtl/updown_counter_param.sv
// updown_counter_param: modulo up/down counter with load, prescaler, wrap/saturate and
// terminal-count, wrap-pulse and sticky-overflow flags.
module updown_counter_param
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flag,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mode_sat,
  input  logic             clr_sticky,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap_pulse,
  output logic             ovf_sticky
);
  localparam wide_t MOD = wide_t'(MODULUS);
  localparam wide_t TOP = wide_t'(MODULUS - 1);
  logic [WIDTH-1:0] count_q, count_d;
  logic wrap_q, wrap_d, ovf_q, ovf_d, tick, hit;
  wide_t cnt_w, ld_w;
  counter_prescaler #(.PRESCALE(PRESCALE)) u_pre (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .clr  (load),
    .tick (tick)
  );
  // A load takes precedence over a tick, so a limit is only "hit" on an unloaded tick.
  always_comb begin
    cnt_w = wide_t'(count_q);
    ld_w = wide_t'(load_val);
    tc = (flag == DIR_UP) ? (cnt_w == TOP) : (cnt_w == '0);
    hit = tick & ~load & tc;
    count_d = load ? WIDTH'((ld_w >= MOD) ? TOP : ld_w)
            : tick ? WIDTH'(next_count(cnt_w, flag, mode_sat, MOD)) : count_q;
    wrap_d = hit & (mode_sat == MODE_WRAP);
    ovf_d = hit | (ovf_q & ~clr_sticky);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      wrap_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q <= wrap_d;
      ovf_q <= ovf_d;
    end
  end
  assign count = count_q;
  assign wrap_pulse = wrap_q;
  assign ovf_sticky = ovf_q;
endmodule

// File: tb/tb_updown_counter_param.sv
// tb_updown_counter_param: three configurations (M16/P1, M10/P1, M16/P4) driven by shared
// stimulus, checked by a queue-based scoreboard against an arithmetic reference model.
module tb_updown_counter_param;
  typedef struct {
    int idx;
    int cnt;
    bit wrap;
    bit ovf;
    bit tc;
  } exp_t;
  localparam int N = 3;
  int mods[N] = '{16, 10, 16};
  int pres[N] = '{1, 1, 4};
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0, flag = 1'b0, load = 1'b0, mode_sat = 1'b0, clr_sticky = 1'b0;
  logic [3:0] load_val = '0;
  logic [3:0] cnt_o[N];
  logic tc_o[N], wp_o[N], ov_o[N];
  int m_cnt[N], m_ph[N];
  bit m_wr[N], m_ov[N];
  exp_t q[$];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  updown_counter_param #(.WIDTH(4), .MODULUS(16), .PRESCALE(1)) dut0 (
    .clk(clk), .reset(reset), .en(en), .flag(flag), .load(load), .load_val(load_val),
    .mode_sat(mode_sat), .clr_sticky(clr_sticky), .count(cnt_o[0]), .tc(tc_o[0]),
    .wrap_pulse(wp_o[0]), .ovf_sticky(ov_o[0]));
  updown_counter_param #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) dut1 (
    .clk(clk), .reset(reset), .en(en), .flag(flag), .load(load), .load_val(load_val),
    .mode_sat(mode_sat), .clr_sticky(clr_sticky), .count(cnt_o[1]), .tc(tc_o[1]),
    .wrap_pulse(wp_o[1]), .ovf_sticky(ov_o[1]));
  updown_counter_param #(.WIDTH(4), .MODULUS(16), .PRESCALE(4)) dut2 (
    .clk(clk), .reset(reset), .en(en), .flag(flag), .load(load), .load_val(load_val),
    .mode_sat(mode_sat), .clr_sticky(clr_sticky), .count(cnt_o[2]), .tc(tc_o[2]),
    .wrap_pulse(wp_o[2]), .ovf_sticky(ov_o[2]));

  task automatic check(input string name, input int idx, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s dut%0d actual %0d required %0d at %0t", name, idx, act, req, $time);
    end
  endtask

  // Reference: count as a plain integer in 0..M-1, phase as an integer modulo P.
  task automatic drive(input bit r, input bit e, input bit f, input bit l, input int lv,
                       input bit s, input bit c);
    @(negedge clk);
    reset = r; en = e; flag = f; load = l; load_val = 4'(lv); mode_sat = s; clr_sticky = c;
    for (int i = 0; i < N; i++) begin
      int m, p;
      bit tk, h;
      m = mods[i]; p = pres[i]; h = 0;
      if (r) begin
        m_cnt[i] = 0; m_ph[i] = 0; m_wr[i] = 0; m_ov[i] = 0;
      end else begin
        tk = e && (m_ph[i] == p - 1);
        if (l) begin
          m_cnt[i] = (lv >= m) ? m - 1 : lv;
          m_ph[i] = 0;
        end else begin
          if (e) m_ph[i] = (m_ph[i] + 1) % p;
          if (tk && !f) begin
            if (m_cnt[i] == m - 1) begin h = 1; if (!s) m_cnt[i] = 0; end
            else m_cnt[i]++;
          end else if (tk && f) begin
            if (m_cnt[i] == 0) begin h = 1; if (!s) m_cnt[i] = m - 1; end
            else m_cnt[i]--;
          end
        end
        m_wr[i] = h && !s;
        m_ov[i] = h || (m_ov[i] && !c);
      end
      q.push_back('{i, m_cnt[i], m_wr[i], m_ov[i], f ? (m_cnt[i] == 0) : (m_cnt[i] == m - 1)});
    end
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      while (q.size() > 0) begin
        x = q.pop_front();
        check("count", x.idx, int'(cnt_o[x.idx]), x.cnt);
        check("wrap_pulse", x.idx, int'(wp_o[x.idx]), int'(x.wrap));
        check("ovf_sticky", x.idx, int'(ov_o[x.idx]), int'(x.ovf));
        check("tc", x.idx, int'(tc_o[x.idx]), int'(x.tc));
      end
    end
  end

  initial begin : driver
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    repeat (17) drive(0, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 1, 0, 0, 0);
    repeat (3) drive(0, 1, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 14, 0, 0);
    repeat (3) drive(0, 1, 0, 0, 0, 1, 0);
    drive(0, 1, 1, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 12, 0, 1);
    repeat (2) drive(0, 1, 0, 0, 0, 0, 0);
    repeat (2) drive(0, 1, 1, 0, 0, 0, 0);
    repeat (6) drive(0, 1, 0, 0, 0, 0, 0);
    repeat (3) drive(0, 0, 0, 0, 0, 0, 0);
    repeat (6) drive(0, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 7, 0, 0);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      check("async_rst_count", i, int'(cnt_o[i]), 0);
      check("async_rst_ovf", i, int'(ov_o[i]), 0);
      m_cnt[i] = 0; m_ph[i] = 0; m_wr[i] = 0; m_ov[i] = 0;
    end
    drive(1, 1, 0, 1, 5, 0, 0);
    for (int k = 0; k < 3000; k++)
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 19) == 0, int'($urandom_range(0, 15)),
            $urandom_range(0, 4) == 0, $urandom_range(0, 29) == 0);
    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual %0d required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
